// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one go/ds memory-read controller among NREQ requesters.
// Latency: req sampled in IDLE -> go next cycle; ds in WAIT -> done/err pulse next cycle.
// Backpressure: req is level-held until done/err; new requests wait for the next IDLE cycle.
module mem_read_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            done,
    output logic            err,
    output logic            busy,
    output logic            go,
    input  logic            ds
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [CW-1:0]   cnt;
    logic            cnt_max;
    int              j;

    assign cnt_max = (cnt == CW'(TIMEOUT - 1));

    // First set request bit searching ptr, ptr+1, ... with wrap at NREQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        j        = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!pick_vld && req[PW'(j)]) begin
                pick_vld = 1'b1;
                pick     = PW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (ds) begin
                    state_nxt = S_DONE;
                end else if (cnt_max) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        go   = (state == S_ISSUE);
        done = (state == S_DONE);
        err  = (state == S_ERR);
        busy = (state != S_IDLE);
    end

    // Grant, winner index, rotation pointer and WAIT cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            win <= '0;
            cnt <= '0;
            gnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        win <= pick;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (!ds && !cnt_max) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    gnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter (NREQ=4, TIMEOUT=16); outputs sampled 1ns after each rising edge.
module tb_mem_read_arbiter;
    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       done;
    logic       err;
    logic       busy;
    logic       go;
    logic       ds;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected {go,done,err,busy} per state
    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_ISS  = 4'b1001;
    localparam logic [3:0] O_WAIT = 4'b0001;
    localparam logic [3:0] O_DONE = 4'b0101;
    localparam logic [3:0] O_ERR  = 4'b0011;

    mem_read_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .done  (done),
        .err   (err),
        .busy  (busy),
        .go    (go),
        .ds    (ds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic [3:0] eg, input logic [3:0] eo);
        @(posedge clk);
        #1;
        n_chk++;
        assert ({gnt, go, done, err, busy} === {eg, eo})
        else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%b go/done/err/busy=%b, expected gnt=%b go/done/err/busy=%b",
                   tag, gnt, {go, done, err, busy}, eg, eo);
        end
    endtask

    initial begin
        logic [3:0] g;

        // 1. reset held with all requests pending
        reset = 1'b1;
        req   = 4'b1111;
        ds    = 1'b0;
        cyc("rst_a", 4'b0000, O_IDLE);
        cyc("rst_b", 4'b0000, O_IDLE);
        reset = 1'b0;
        cyc("t1_issue", 4'b0001, O_ISS);
        req = 4'b0000;
        cyc("t1_wait", 4'b0001, O_WAIT);
        ds = 1'b1;
        cyc("t1_done", 4'b0001, O_DONE);
        ds = 1'b0;
        cyc("t1_idle", 4'b0000, O_IDLE);

        // 2. single request, ds on third WAIT cycle (ptr=1 -> picks bit 2)
        req = 4'b0100;
        cyc("t2_issue", 4'b0100, O_ISS);
        cyc("t2_w1", 4'b0100, O_WAIT);
        cyc("t2_w2", 4'b0100, O_WAIT);
        cyc("t2_w3", 4'b0100, O_WAIT);
        ds  = 1'b1;
        req = 4'b0000;
        cyc("t2_done", 4'b0100, O_DONE);
        ds = 1'b0;
        cyc("t2_idle", 4'b0000, O_IDLE);
        // ptr should now be 3
        req = 4'b1111;
        cyc("t2_ptr3", 4'b1000, O_ISS);
        req = 4'b0000;
        cyc("t2p_wait", 4'b1000, O_WAIT);
        ds = 1'b1;
        cyc("t2p_done", 4'b1000, O_DONE);
        ds = 1'b0;
        cyc("t2p_idle", 4'b0000, O_IDLE);

        // 3. reset returns ptr to 0, then round robin with all requests held
        reset = 1'b1;
        cyc("t3_rst", 4'b0000, O_IDLE);
        reset = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            g = 4'b0001 << (i % 4);
            cyc($sformatf("rr%0d_issue", i), g, O_ISS);
            cyc($sformatf("rr%0d_wait", i), g, O_WAIT);
            ds = 1'b1;
            cyc($sformatf("rr%0d_done", i), g, O_DONE);
            ds = 1'b0;
            if (i == 4) req = 4'b0000;
            cyc($sformatf("rr%0d_idle", i), 4'b0000, O_IDLE);
        end

        // 4a. timeout: ptr=1, ds never asserted
        req = 4'b0010;
        cyc("t4_issue", 4'b0010, O_ISS);
        req = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            cyc($sformatf("t4_w%0d", k), 4'b0010, O_WAIT);
        end
        cyc("t4_err", 4'b0010, O_ERR);
        cyc("t4_idle", 4'b0000, O_IDLE);

        // 4b. ds on the 16th WAIT cycle wins; ptr advanced to 2 after err
        req = 4'b1111;
        cyc("t4b_issue", 4'b0100, O_ISS);
        req = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            cyc($sformatf("t4b_w%0d", k), 4'b0100, O_WAIT);
        end
        ds = 1'b1;
        cyc("t4b_done", 4'b0100, O_DONE);
        ds = 1'b0;
        cyc("t4b_idle", 4'b0000, O_IDLE);

        // 5. reset mid-WAIT (ptr=3 -> picks bit 0)
        req = 4'b0001;
        cyc("t5_issue", 4'b0001, O_ISS);
        req = 4'b0000;
        cyc("t5_w1", 4'b0001, O_WAIT);
        cyc("t5_w2", 4'b0001, O_WAIT);
        reset = 1'b1;
        cyc("t5_rst", 4'b0000, O_IDLE);
        reset = 1'b0;
        cyc("t5_quiet", 4'b0000, O_IDLE);

        // 6. ptr=0 picks bit 1; requester drops, another raises during WAIT
        req = 4'b1010;
        cyc("t6_issue", 4'b0010, O_ISS);
        cyc("t6_w1", 4'b0010, O_WAIT);
        req = 4'b1100;
        cyc("t6_w2", 4'b0010, O_WAIT);
        cyc("t6_w3", 4'b0010, O_WAIT);
        ds = 1'b1;
        cyc("t6_done", 4'b0010, O_DONE);
        ds = 1'b0;
        cyc("t6_idle", 4'b0000, O_IDLE);
        cyc("t6_next_issue", 4'b0100, O_ISS);
        cyc("t6_next_wait", 4'b0100, O_WAIT);
        ds = 1'b1;
        cyc("t6_next_done", 4'b0100, O_DONE);
        ds  = 1'b0;
        req = 4'b0000;
        cyc("t6_next_idle", 4'b0000, O_IDLE);
        cyc("t6_stay_idle", 4'b0000, O_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
